// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Transmit-side byte FIFO feeding a UART transmitter through a
//               byte_tx / start_tx / done_tx handshake. Bytes enter through a
//               valid/ready write port, are buffered in a DEPTH-entry circular
//               store and are launched one frame at a time.
//               Optional feature macro: UART_TX_FIFO_OVF_EN (sticky overflow
//               flag for writes attempted while full).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    // system-side write port
    input  logic [7:0]              wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    // status
    output logic [$clog2(DEPTH):0]  level,
    output logic                    empty,
    output logic                    overflow,
    input  logic                    ovf_clr,
    // transmitter handshake
    input  logic                    done_tx,
    output logic [7:0]              byte_tx,
    output logic                    start_tx
);

    localparam int c_AW = $clog2(DEPTH);

    // Drain FSM encoding. WAIT_BUSY exists because the transmitter keeps
    // done_tx high for a couple of cycles after the launch pulse, so a high
    // done_tx right after launch does not mean the frame has finished.
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [7:0]          r_mem [DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_AW:0]       r_level;
    logic [7:0]          r_byte_tx;
    logic                r_start_tx;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_launch;

    // Level never exceeds DEPTH and DEPTH is a power of two, so the counter
    // MSB alone marks the full condition.
    assign w_full   = r_level[c_AW];
    assign w_empty  = (r_level == '0);

    // A pop in the same cycle does not open a slot: readiness is purely a
    // function of the registered level.
    assign w_push   = wr_valid && !w_full;

    assign wr_ready = !w_full;
    assign empty    = w_empty;
    assign level    = r_level;
    assign byte_tx  = r_byte_tx;
    assign start_tx = r_start_tx;

    // Storage write; contents need no reset because the pointers and level
    // define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Write pointer advances on every accepted byte, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // Read pointer advances only when a byte is handed to the transmitter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_launch) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy counter; simultaneous push and pop cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_launch})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and launch decode. A launch needs queued data and an idle
    // transmitter, and can only happen from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && done_tx) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!done_tx) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (done_tx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Launch outputs: the pulse lasts exactly one cycle and the byte is only
    // loaded at launch, so it stays stable for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_tx <= 1'b0;
            r_byte_tx  <= 8'h00;
        end else begin
            r_start_tx <= w_launch;
            if (w_launch) begin
                r_byte_tx <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic r_overflow;

    // Sticky overflow: any write attempt while full sets it; a clear in the
    // same cycle as a set loses so that no event is ever missed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (wr_valid && w_full) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;
`else
    // Feature disabled: flag tied low, clear input intentionally unused.
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ovf_clr;
    assign overflow         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo. A DEPTH=16
//               instance covers reset, latency, handshake, burst, overflow,
//               concurrent push/pop and mid-frame reset; a DEPTH=4 instance
//               covers pointer wrap. Transmitter models hold done_tx high for
//               two cycles after each start pulse, then busy for N cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int c_BUSY4 = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- DEPTH=16 instance ----------------
    logic [7:0] wr_data16   = 8'h00;
    logic       wr_valid16  = 1'b0;
    logic       ovf_clr16   = 1'b0;
    logic       wr_ready16;
    logic [4:0] level16;
    logic       empty16;
    logic       overflow16;
    logic       done16;
    logic [7:0] byte16;
    logic       start16;

    logic       auto16     = 1'b0;
    logic       man_done16 = 1'b1;
    int         busy16     = 100;
    int         m16_cnt    = 0;
    logic [7:0] cap16 [512];
    int         cap16_n    = 0;
    logic [7:0] last16     = 8'h00;
    int         stab_err16 = 0;
    int         coll_err16 = 0;

    assign done16 = auto16 ? !(m16_cnt > 0 && m16_cnt <= busy16) : man_done16;

    uart_tx_fifo #(.DEPTH(16)) u16 (
        .clk(clk), .rst(rst),
        .wr_data(wr_data16), .wr_valid(wr_valid16), .wr_ready(wr_ready16),
        .level(level16), .empty(empty16), .overflow(overflow16), .ovf_clr(ovf_clr16),
        .done_tx(done16), .byte_tx(byte16), .start_tx(start16)
    );

    // Transmitter model + capture for the DEPTH=16 instance
    always @(posedge clk) begin
        if (auto16 && m16_cnt != 0 && byte16 !== last16) stab_err16 <= stab_err16 + 1;
        if (start16 === 1'b1) begin
            if (auto16 && m16_cnt != 0) coll_err16 <= coll_err16 + 1;
            if (cap16_n < 512) cap16[cap16_n] <= byte16;
            cap16_n <= cap16_n + 1;
            last16  <= byte16;
            m16_cnt <= 2 + busy16;
        end else if (m16_cnt != 0) begin
            m16_cnt <= m16_cnt - 1;
        end
    end

    // ---------------- DEPTH=4 instance ----------------
    logic [7:0] wr_data4  = 8'h00;
    logic       wr_valid4 = 1'b0;
    logic       ovf_clr4  = 1'b0;
    logic       wr_ready4;
    logic [2:0] level4;
    logic       empty4;
    logic       overflow4;
    logic       done4;
    logic [7:0] byte4;
    logic       start4;

    int         m4_cnt    = 0;
    logic [7:0] cap4 [128];
    int         cap4_n    = 0;
    logic [7:0] last4     = 8'h00;
    int         stab_err4 = 0;
    int         coll_err4 = 0;

    assign done4 = !(m4_cnt > 0 && m4_cnt <= c_BUSY4);

    uart_tx_fifo #(.DEPTH(4)) u4 (
        .clk(clk), .rst(rst),
        .wr_data(wr_data4), .wr_valid(wr_valid4), .wr_ready(wr_ready4),
        .level(level4), .empty(empty4), .overflow(overflow4), .ovf_clr(ovf_clr4),
        .done_tx(done4), .byte_tx(byte4), .start_tx(start4)
    );

    always @(posedge clk) begin
        if (m4_cnt != 0 && byte4 !== last4) stab_err4 <= stab_err4 + 1;
        if (start4 === 1'b1) begin
            if (m4_cnt != 0) coll_err4 <= coll_err4 + 1;
            if (cap4_n < 128) cap4[cap4_n] <= byte4;
            cap4_n <= cap4_n + 1;
            last4  <= byte4;
            m4_cnt <= 2 + c_BUSY4;
        end else if (m4_cnt != 0) begin
            m4_cnt <= m4_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; wr_valid16 = 1'b0; wr_valid4 = 1'b0; man_done16 = 1'b1; auto16 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        n_vec++; if (byte16 !== 8'h00) begin n_err++; $display("FAIL reset_byte_tx: got %h exp 00", byte16); end
        n_vec++; if (start16 !== 1'b0) begin n_err++; $display("FAIL reset_start_tx: got %b exp 0", start16); end
        n_vec++; if (level16 !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d exp 0", level16); end
        n_vec++; if (empty16 !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b exp 1", empty16); end
        n_vec++; if (wr_ready16 !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %b exp 1", wr_ready16); end
        n_vec++; if (overflow16 !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b exp 0", overflow16); end
    endtask

    task automatic test_single();
        wr_data16 = 8'hA5; wr_valid16 = 1'b1;
        tick();                       // write accepted at this edge
        wr_valid16 = 1'b0;
        n_vec++; if (empty16 !== 1'b0) begin n_err++; $display("FAIL single_empty_n1: got %b exp 0", empty16); end
        n_vec++; if (level16 !== 5'd1) begin n_err++; $display("FAIL single_level_n1: got %0d exp 1", level16); end
        n_vec++; if (start16 !== 1'b0) begin n_err++; $display("FAIL single_start_n1: got %b exp 0", start16); end
        tick();                       // launch edge
        n_vec++; if (start16 !== 1'b1) begin n_err++; $display("FAIL single_start_n2: got %b exp 1", start16); end
        n_vec++; if (byte16 !== 8'hA5) begin n_err++; $display("FAIL single_byte_n2: got %h exp a5", byte16); end
        n_vec++; if (empty16 !== 1'b1) begin n_err++; $display("FAIL single_empty_n2: got %b exp 1", empty16); end
        tick();
        n_vec++; if (start16 !== 1'b0) begin n_err++; $display("FAIL single_pulse_len: got %b exp 0", start16); end
        // queue a second byte while the transmitter still reports done_tx=1
        wr_data16 = 8'h3C; wr_valid16 = 1'b1;
        tick();
        wr_valid16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (start16 !== 1'b0) begin n_err++; $display("FAIL busy_hold_start[%0d]: got %b exp 0", i, start16); end
        end
        n_vec++; if (level16 !== 5'd1) begin n_err++; $display("FAIL busy_hold_level: got %0d exp 1", level16); end
        man_done16 = 1'b0;
        tick(); tick();
        n_vec++; if (start16 !== 1'b0) begin n_err++; $display("FAIL frame_start: got %b exp 0", start16); end
        n_vec++; if (byte16 !== 8'hA5) begin n_err++; $display("FAIL frame_byte_hold: got %h exp a5", byte16); end
        man_done16 = 1'b1;
        tick();                       // done seen, back to IDLE
        n_vec++; if (start16 !== 1'b0) begin n_err++; $display("FAIL done_gap_start: got %b exp 0", start16); end
        tick();                       // second launch
        n_vec++; if (start16 !== 1'b1) begin n_err++; $display("FAIL second_start: got %b exp 1", start16); end
        n_vec++; if (byte16 !== 8'h3C) begin n_err++; $display("FAIL second_byte: got %h exp 3c", byte16); end
        tick();
        n_vec++; if (start16 !== 1'b0) begin n_err++; $display("FAIL second_pulse_len: got %b exp 0", start16); end
        man_done16 = 1'b0; tick();
        man_done16 = 1'b1; tick(); tick();
    endtask

    task automatic test_burst();
        int base;
        int guard;
        logic exp_rdy;
        auto16 = 1'b0; man_done16 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            wr_data16 = 8'(i); wr_valid16 = 1'b1;
            tick();
            exp_rdy = (i < 16);
            n_vec++; if (wr_ready16 !== exp_rdy) begin n_err++; $display("FAIL burst_wr_ready[%0d]: got %b exp %b", i, wr_ready16, exp_rdy); end
        end
        wr_data16 = 8'hEE;            // 17th write, must be dropped
        tick();
        n_vec++; if (level16 !== 5'd16) begin n_err++; $display("FAIL drop_level: got %0d exp 16", level16); end
`ifdef UART_TX_FIFO_OVF_EN
        n_vec++; if (overflow16 !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b exp 1", overflow16); end
        ovf_clr16 = 1'b1;
        tick();                       // set and clear together
        n_vec++; if (overflow16 !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b exp 1", overflow16); end
        wr_valid16 = 1'b0;
        tick();
        n_vec++; if (overflow16 !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b exp 0", overflow16); end
`else
        n_vec++; if (overflow16 !== 1'b0) begin n_err++; $display("FAIL ovf_tied: got %b exp 0", overflow16); end
        ovf_clr16 = 1'b1;
        tick();
        n_vec++; if (overflow16 !== 1'b0) begin n_err++; $display("FAIL ovf_tied_clr: got %b exp 0", overflow16); end
        wr_valid16 = 1'b0;
        tick();
`endif
        ovf_clr16 = 1'b0; wr_valid16 = 1'b0;
        n_vec++; if (level16 !== 5'd16) begin n_err++; $display("FAIL drop_level2: got %0d exp 16", level16); end
        guard = 0;
        while (m16_cnt != 0 && guard < 500) begin tick(); guard++; end
        base = cap16_n;
        busy16 = 100; auto16 = 1'b1;
        guard = 0;
        while (!(cap16_n == base + 16 && empty16 === 1'b1 && m16_cnt == 0) && guard < 4000) begin tick(); guard++; end
        n_vec++; if (guard >= 4000) begin n_err++; $display("FAIL burst_timeout: got %0d frames exp 16", cap16_n - base); end
        repeat (3) tick();
        n_vec++; if (cap16_n - base !== 16) begin n_err++; $display("FAIL burst_frames: got %0d exp 16", cap16_n - base); end
        for (int i = 0; i < 16; i++) begin
            n_vec++; if (cap16[base+i] !== 8'(i + 1)) begin n_err++; $display("FAIL burst_order[%0d]: got %h exp %h", i, cap16[base+i], 8'(i + 1)); end
        end
        n_vec++; if (stab_err16 !== 0) begin n_err++; $display("FAIL burst_byte_stable: got %0d changes exp 0", stab_err16); end
        n_vec++; if (coll_err16 !== 0) begin n_err++; $display("FAIL burst_collision: got %0d exp 0", coll_err16); end
    endtask

    task automatic test_push_pop();
        int base;
        int guard;
        auto16 = 1'b0; man_done16 = 1'b0;
        tick();
        base = cap16_n;
        for (int i = 0; i < 5; i++) begin
            wr_data16 = 8'(8'h50 + i); wr_valid16 = 1'b1;
            tick();
        end
        wr_valid16 = 1'b0;
        n_vec++; if (level16 !== 5'd5) begin n_err++; $display("FAIL pp_level_before: got %0d exp 5", level16); end
        man_done16 = 1'b1; wr_data16 = 8'h55; wr_valid16 = 1'b1;
        tick();                       // push and launch on the same edge
        wr_valid16 = 1'b0;
        n_vec++; if (level16 !== 5'd5) begin n_err++; $display("FAIL pp_level_same: got %0d exp 5", level16); end
        n_vec++; if (start16 !== 1'b1) begin n_err++; $display("FAIL pp_start: got %b exp 1", start16); end
        n_vec++; if (byte16 !== 8'h50) begin n_err++; $display("FAIL pp_byte: got %h exp 50", byte16); end
        busy16 = 3; auto16 = 1'b1;
        guard = 0;
        while (!(cap16_n == base + 6 && empty16 === 1'b1 && m16_cnt == 0) && guard < 300) begin tick(); guard++; end
        n_vec++; if (guard >= 300) begin n_err++; $display("FAIL pp_timeout: got %0d frames exp 6", cap16_n - base); end
        for (int i = 0; i < 6; i++) begin
            n_vec++; if (cap16[base+i] !== 8'(8'h50 + i)) begin n_err++; $display("FAIL pp_order[%0d]: got %h exp %h", i, cap16[base+i], 8'(8'h50 + i)); end
        end
        n_vec++; if (coll_err16 !== 0 || stab_err16 !== 0) begin n_err++; $display("FAIL pp_handshake: got %0d/%0d exp 0/0", coll_err16, stab_err16); end
        auto16 = 1'b0; man_done16 = 1'b1;
    endtask

    task automatic test_wrap();
        int guard;
        int tmo;
        tmo = 0;
        wr_valid4 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data4 = 8'(8'h20 + i);
            guard = 0;
            while (wr_ready4 !== 1'b1 && guard < 100) begin tick(); guard++; end
            if (guard >= 100) tmo++;
            tick();
        end
        wr_valid4 = 1'b0;
        guard = 0;
        while (!(cap4_n == 40 && empty4 === 1'b1 && m4_cnt == 0) && guard < 2000) begin tick(); guard++; end
        n_vec++; if (tmo != 0 || guard >= 2000) begin n_err++; $display("FAIL wrap_timeout: got %0d frames exp 40", cap4_n); end
        repeat (5) tick();
        n_vec++; if (cap4_n !== 40) begin n_err++; $display("FAIL wrap_frames: got %0d exp 40", cap4_n); end
        for (int i = 0; i < 40; i++) begin
            n_vec++; if (cap4[i] !== 8'(8'h20 + i)) begin n_err++; $display("FAIL wrap_order[%0d]: got %h exp %h", i, cap4[i], 8'(8'h20 + i)); end
        end
        n_vec++; if (coll_err4 !== 0 || stab_err4 !== 0) begin n_err++; $display("FAIL wrap_handshake: got %0d/%0d exp 0/0", coll_err4, stab_err4); end
        n_vec++; if (level4 !== 3'd0) begin n_err++; $display("FAIL wrap_level: got %0d exp 0", level4); end
    endtask

    task automatic test_reset_mid();
        int base;
        auto16 = 1'b0; man_done16 = 1'b1;
        base = cap16_n;
        wr_valid16 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data16 = 8'(8'h61 + i);
            tick();
        end
        wr_valid16 = 1'b0;
        man_done16 = 1'b0;
        tick(); tick();               // frame 0x61 in progress, FSM in WAIT_DONE
        n_vec++; if (level16 !== 5'd3) begin n_err++; $display("FAIL rm_level_queued: got %0d exp 3", level16); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (level16 !== 5'd0) begin n_err++; $display("FAIL rm_level: got %0d exp 0", level16); end
        n_vec++; if (start16 !== 1'b0) begin n_err++; $display("FAIL rm_start: got %b exp 0", start16); end
        n_vec++; if (byte16 !== 8'h00) begin n_err++; $display("FAIL rm_byte: got %h exp 00", byte16); end
        n_vec++; if (empty16 !== 1'b1) begin n_err++; $display("FAIL rm_empty: got %b exp 1", empty16); end
        wr_data16 = 8'h77; wr_valid16 = 1'b1;
        tick();
        wr_valid16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (start16 !== 1'b0) begin n_err++; $display("FAIL rm_no_launch[%0d]: got %b exp 0", i, start16); end
        end
        n_vec++; if (level16 !== 5'd1) begin n_err++; $display("FAIL rm_level_new: got %0d exp 1", level16); end
        man_done16 = 1'b1;
        tick();
        n_vec++; if (start16 !== 1'b1) begin n_err++; $display("FAIL rm_launch: got %b exp 1", start16); end
        n_vec++; if (byte16 !== 8'h77) begin n_err++; $display("FAIL rm_launch_byte: got %h exp 77", byte16); end
        tick();
        n_vec++; if (cap16_n - base !== 2) begin n_err++; $display("FAIL rm_frames: got %0d exp 2", cap16_n - base); end
        n_vec++; if (cap16[base+1] !== 8'h77) begin n_err++; $display("FAIL rm_frame_byte: got %h exp 77", cap16[base+1]); end
        man_done16 = 1'b0; tick();
        man_done16 = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_push_pop();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
